// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame/baud constants
// used by both the transmitter and receiver sides.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    localparam int UART_DEFAULT_CLKS_PER_BIT = 104;
    localparam int UART_DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync2.sv
// Generic two-flop synchronizer; RST_VAL sets the value both flops reset to.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 (or 8E1 with UART_RX_PARITY_EN defined) into a one-entry
// holding register with valid/rd handshake and sticky overrun.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      uartRxPin,
    input  logic                      rd,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    output logic                      frameErr,
    output logic                      overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                      parityErr
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL_RELOAD = CW'(CLKS_PER_BIT - 1);
    // The edge is seen two clocks after the pin, so START loads half a bit minus one.
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]    LAST_BIT    = 3'(UART_DATA_BITS - 1);

    logic rx_sync;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (uartRxPin),
        .q     (rx_sync)
    );

    uart_rx_state_t            state_reg, state_next;
    logic [CW-1:0]             cnt_reg, cnt_next;
    logic [2:0]                bit_idx_reg, bit_idx_next;
    logic [UART_DATA_BITS-1:0] shift_reg, shift_next;
    logic                      stop_bit_reg, stop_bit_next;
    logic                      load_reg, load_next;
    logic                      prev_reg;
`ifdef UART_RX_PARITY_EN
    logic                      par_err_reg, par_err_next;
`endif

    logic [UART_DATA_BITS-1:0] data_reg;
    logic                      valid_reg;
    logic                      frame_err_reg;
    logic                      overrun_reg;
`ifdef UART_RX_PARITY_EN
    logic                      parity_err_reg;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
            stop_bit_reg <= 1'b0;
            load_reg     <= 1'b0;
            prev_reg     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_err_reg  <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            bit_idx_reg  <= bit_idx_next;
            shift_reg    <= shift_next;
            stop_bit_reg <= stop_bit_next;
            load_reg     <= load_next;
            prev_reg     <= rx_sync;
`ifdef UART_RX_PARITY_EN
            par_err_reg  <= par_err_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        bit_idx_next  = bit_idx_reg;
        shift_next    = shift_reg;
        stop_bit_next = stop_bit_reg;
        load_next     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_next  = par_err_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (prev_reg && !rx_sync) begin
                    state_next = START;
                    cnt_next   = HALF_RELOAD;
                end
            end
            START: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else if (rx_sync) begin
                    state_next = IDLE;
                end else begin
                    state_next   = DATA;
                    cnt_next     = FULL_RELOAD;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    shift_next = {rx_sync, shift_reg[UART_DATA_BITS-1:1]};
                    cnt_next   = FULL_RELOAD;
                    if (bit_idx_reg == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    par_err_next = (^shift_reg) ^ rx_sync;
                    cnt_next     = FULL_RELOAD;
                    state_next   = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - 1'b1;
                end else begin
                    // Hand the frame to the holding register next cycle; no stop-bit wait.
                    stop_bit_next = rx_sync;
                    load_next     = 1'b1;
                    state_next    = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_reg       <= '0;
            valid_reg      <= 1'b0;
            frame_err_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
        end else if (load_reg) begin
            if (!valid_reg || rd) begin
                data_reg       <= shift_reg;
                frame_err_reg  <= ~stop_bit_reg;
                valid_reg      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err_reg <= par_err_reg;
`endif
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (rd && valid_reg) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign data      = data_reg;
    assign valid     = valid_reg;
    assign frameErr  = frame_err_reg;
    assign overrun   = overrun_reg;
`ifdef UART_RX_PARITY_EN
    assign parityErr = parity_err_reg;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; parity cases run when
// UART_RX_PARITY_EN is defined.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NB  = 11;
    localparam int LAT = 172;   // 1 + 2 + 8 + 10*16 + 1 edges after the drive
`else
    localparam int NB  = 10;
    localparam int LAT = 156;   // 1 + 2 + 8 + 9*16 + 1 edges after the drive
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pin = 1'b1;
    logic       rd  = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rise_cyc = -1;
    int start_cyc;
    logic valid_q = 1'b0;

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clock     (clk),
        .reset     (rst),
        .uartRxPin (pin),
        .rd        (rd),
        .data      (data),
        .valid     (valid),
        .frameErr  (frame_err),
        .overrun   (overrun)
`ifdef UART_RX_PARITY_EN
        ,
        .parityErr (parity_err)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid && !valid_q) rise_cyc = cyc;
        valid_q = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one frame bit-per-C-cycles; ncyc<=0 sends the whole frame,
    // rd is pulsed for the cycle index rd_at (sampled on edge rd_at+1).
    task automatic send(input logic [7:0] b, input logic par, input logic stop,
                        input int ncyc, input int rd_at);
        logic [10:0] fr;
        int n;
`ifdef UART_RX_PARITY_EN
        fr = {stop, par, b, 1'b0};
`else
        fr = {1'b1, stop, b, 1'b0};
`endif
        n = (ncyc <= 0) ? NB * C : ncyc;
        $display("tx byte %02h par %0d stop %0d cycles %0d rd_at %0d", b, par, stop, n, rd_at);
        for (int i = 0; i < n; i++) begin
            pin = fr[i / C];
            rd  = (i == rd_at);
            @(posedge clk);
            #1;
        end
        rd = 1'b0;
    endtask

    task automatic do_rd();
        rd = 1'b1;
        wait_cyc(1);
        rd = 1'b0;
    endtask

    initial begin
        wait_cyc(3);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_data", 32'(data), 32'h00);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        wait_cyc(4);

        // 0x41, good stop, latency from drive to valid
        start_cyc = cyc;
        send(8'h41, 1'b0, 1'b1, 0, -1);
        check("lat_41", 32'(rise_cyc - start_cyc), 32'(LAT));
        check("valid_41", 32'(valid), 32'd1);
        check("data_41", 32'(data), 32'h41);
        check("fe_41", 32'(frame_err), 32'd0);
        do_rd();
        check("rd_valid_41", 32'(valid), 32'd0);
        check("rd_data_41", 32'(data), 32'h41);
        do_rd();
        check("rd_idle_valid", 32'(valid), 32'd0);

        // 8-cycle low glitch, then 0xA5
        pin = 1'b0;
        wait_cyc(8);
        pin = 1'b1;
        wait_cyc(3 * C);
        check("glitch_valid", 32'(valid), 32'd0);
        check("glitch_state", 32'(dut.state_reg), 32'(IDLE));
        send(8'hA5, 1'b0, 1'b1, 0, -1);
        check("valid_a5", 32'(valid), 32'd1);
        check("data_a5", 32'(data), 32'hA5);
        do_rd();

        // 0x3C with a low stop bit, line then held low
        send(8'h3C, 1'b0, 1'b0, 0, -1);
        wait_cyc(12 * C);
        check("valid_3c", 32'(valid), 32'd1);
        check("data_3c", 32'(data), 32'h3C);
        check("fe_3c", 32'(frame_err), 32'd1);
        check("low_state", 32'(dut.state_reg), 32'(IDLE));
        pin = 1'b1;
        wait_cyc(12 * C);
        check("noretrig_ovr", 32'(overrun), 32'd0);
        check("noretrig_data", 32'(data), 32'h3C);
        do_rd();

        // back-to-back 0x11 / 0x22 without rd
        send(8'h11, 1'b0, 1'b1, 0, -1);
        send(8'h22, 1'b0, 1'b1, 0, -1);
        check("ovr_valid", 32'(valid), 32'd1);
        check("ovr_data", 32'(data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_fe", 32'(frame_err), 32'd0);
        do_rd();
        check("ovr_rd_valid", 32'(valid), 32'd0);
        check("ovr_rd_flag", 32'(overrun), 32'd0);
        send(8'h33, 1'b0, 1'b1, 0, -1);
        check("data_33", 32'(data), 32'h33);
        check("valid_33", 32'(valid), 32'd1);
        // rd coincides with the load edge of 0x44
        send(8'h44, 1'b0, 1'b1, 0, LAT - 1);
        check("coinc_valid", 32'(valid), 32'd1);
        check("coinc_data", 32'(data), 32'h44);
        check("coinc_ovr", 32'(overrun), 32'd0);

        // reset in the middle of data bit 4 of 0xFF
        send(8'hFF, 1'b1, 1'b1, 5 * C + C / 2, -1);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_fe", 32'(frame_err), 32'd0);
        check("midrst_ovr", 32'(overrun), 32'd0);
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        send(8'h5A, 1'b0, 1'b1, 0, -1);
        check("valid_5a", 32'(valid), 32'd1);
        check("data_5a", 32'(data), 32'h5A);
        check("fe_5a", 32'(frame_err), 32'd0);
        do_rd();

`ifdef UART_RX_PARITY_EN
        send(8'h07, 1'b1, 1'b1, 0, -1);
        check("par_good_data", 32'(data), 32'h07);
        check("par_good", 32'(parity_err), 32'd0);
        do_rd();
        send(8'h07, 1'b0, 1'b1, 0, -1);
        check("par_bad", 32'(parity_err), 32'd1);
        do_rd();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8 data bits, LSB first, one stop bit, optional even parity. Converts the RX pin into bytes held in a one-entry holding register with a valid/read handshake. It is the receive counterpart of the existing UART transmitter and sits beside it under the register file, sharing the core clock and reset. It will feed a memory-mapped receive register for the CPU.

## Interface
- CLKS_PER_BIT, 104, clock cycles per bit (12 MHz / 115200); must be ≥ 4
- clock  in  1  core clock; all state on posedge
- reset  in  1  asynchronous, active-high; clears all state
- uartRxPin  in  1  serial line; idles high; asynchronous to clock
- rd  in  1  consume the held byte; honoured only while valid = 1
- data  out  8  received byte, stable while valid = 1
- valid  out  1  holding register full
- frameErr  out  1  stop bit of the held byte was sampled low
- overrun  out  1  sticky: a byte was lost because valid was still high
- parityErr  out  1  present only with UART_RX_PARITY_EN; held byte failed even parity

## Operation
- uartRxPin passes through a 2-flop synchronizer. Both flops reset to 1.
- State machine: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: a falling edge on the synchronized line (previous 1, current 0) loads the bit counter and enters START. A line held low never retriggers.
- START: after CLKS_PER_BIT/2 cycles (integer divide), resample the line.
  - 0 → DATA, bit index 0.
  - 1 → false start, return to IDLE; no output change.
- DATA: sample every CLKS_PER_BIT cycles, shifting LSB first into the shift register. After bit index 7, go to PARITY (macro) or STOP.
- PARITY: sample once. The error is the XOR of the 8 data bits and the parity bit; 1 means a parity error.
- STOP: sample once, then always return to IDLE in the next cycle. No wait for a full stop-bit time, so back-to-back frames are accepted.
- Load at the STOP sample:
  - valid = 0, or rd = 1 in the same cycle → load data, frameErr = ~stop, parityErr; set valid = 1.
  - valid = 1 and rd = 0 → discard the new byte; keep the held byte and its flags; set overrun = 1.
- rd with valid = 1 and no simultaneous load → valid = 0 and overrun = 0. data and the flags keep their values.
- rd with valid = 0 → ignored.
- Width rules:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits, counts down and reloads to CLKS_PER_BIT-1.
  - Bit index: 3 bits; wraps only by state exit.
- Reset, at any time including mid-frame: state = IDLE, counters = 0, shift register = 0. Outputs: data = 0, valid = 0, frameErr = 0, overrun = 0, parityErr = 0.

## Timing
- Sync latency: 2 clocks from pin to the FSM.
- START sample at falling edge + 2 + CLKS_PER_BIT/2 cycles. Every later sample is CLKS_PER_BIT cycles after the previous one.
- valid, data and flags update on the clock edge following the STOP sample cycle. Overall: 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (+CLKS_PER_BIT with parity) + 1 cycles after the pin edge.
- rd is sampled on the same edge; valid falls on that edge.
- overrun is sticky and clears only via rd or reset.
- Load on the same edge as rd: the new byte wins, valid stays 1, overrun unchanged.

## Configuration
- UART_RX_PARITY_EN defined: PARITY state and parityErr port exist; frame is 11 bits (start, 8 data, even parity, stop).
- Undefined: no PARITY state, no parityErr port; frame is 10 bits; STOP follows data bit 7.

## Structure
- Shared package uart_pkg:
  - state enum uart_rx_state_t (IDLE, START, DATA, PARITY, STOP)
  - constant UART_DEFAULT_CLKS_PER_BIT = 104
  - constant UART_DATA_BITS = 8
- The transmitter side uses the same package constants.
- One sub-module: sync2, a generic 2-flop synchronizer with a reset-value parameter, instantiated with reset value 1.

## Test plan
- CLKS_PER_BIT = 16, send 0x41 with a good stop bit → valid rises at the computed cycle, data = 0x41, frameErr = 0; rd pulse → valid = 0.
- 8-cycle low glitch on an idle line → no valid, FSM back in IDLE; then 0xA5 is received correctly.
- Send 0x3C with stop bit = 0, then release the line high → valid = 1, data = 0x3C, frameErr = 1; line held low afterwards causes no retrigger.
- Send 0x11 then 0x22 back-to-back, no rd → data = 0x11, overrun = 1. rd → valid = 0, overrun = 0. Send 0x33 → data = 0x33. Also: rd on the load edge of 0x44 → valid stays 1, data = 0x44, overrun = 0.
- Assert reset at data bit 4 of 0xFF → all outputs 0 immediately. After release, 0x5A is received correctly.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 → parityErr = 0; with parity bit 0 → parityErr = 1.
